// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
// Shared types and constants for the IRQ responder peer model.
//   irq_word_t   : 32-bit IRQ word carried on the CPU link
//   resp_state_e : responder FSM states (IDLE -> WAIT -> SEND -> IDLE)
//   RESP_KEY     : constant mixed into every response word
// ---------------------------------------------------------------------------
package irq_pkg;

    typedef logic [31:0] irq_word_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SEND
    } resp_state_e;

    localparam irq_word_t RESP_KEY = 32'hA5A5_5A5A;

endpackage

// File: rtl/irq_fifo.sv
// ---------------------------------------------------------------------------
// irq_fifo
// Synchronous request FIFO for the IRQ responder.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset, empties the FIFO
//   push  : write request (ignored when full unless a pop happens this cycle)
//   wdata : word to write
//   pop   : read request (ignored when empty)
//   rdata : head of the FIFO (valid while !empty)
//   full  : DEPTH entries stored
//   empty : no entries stored
// DEPTH must be a power of two, >= 2.
// ---------------------------------------------------------------------------
module irq_fifo
    import irq_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter type         word_t = irq_word_t
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  word_t wdata,
    input  logic  pop,
    output word_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    word_t       mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the head slot, so a push on full is accepted.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/irq_responder.sv
// ---------------------------------------------------------------------------
// irq_responder
// Peer model at the far end of a fake CPU's 32-bit IRQ word link. Every
// change on i_irq is queued; after a data-dependent delay a transformed
// response is driven on o_irq. Consecutive responses always differ. After
// TRANSACTION_NB responses the block raises done and ignores further input.
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset
//   cpu_index : index of the peer CPU, mixed into the response
//   i_irq     : request word from the CPU's outgoing IRQ
//   o_irq     : response word to the CPU's incoming IRQ
//   done      : TRANSACTION_NB responses have been sent
//   drop_cnt  : requests dropped because the FIFO was full (saturating)
// Optional feature: define IRQ_RESPONDER_LOG_EN to print each response and
// each dropped request; cycle behaviour is identical either way.
// ---------------------------------------------------------------------------
module irq_responder
    import irq_pkg::*;
#(
    parameter int unsigned TRANSACTION_NB = 1000,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned MIN_DELAY      = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_index,
    input  logic [31:0] i_irq,
    output logic [31:0] o_irq,
    output logic        done,
    output logic [15:0] drop_cnt
);

    irq_word_t   i_irq_prev;
    irq_word_t   fifo_head;
    irq_word_t   resp;
    irq_word_t   send_val;
    logic        change;
    logic        pop;
    logic        drop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [8:0]  cnt;
    logic [31:0] sent_cnt;
    resp_state_e state;

    assign change   = (i_irq != i_irq_prev) && !done;
    assign pop      = (state == IDLE) && !fifo_empty && !done;
    assign drop     = change && fifo_full && !pop;
    // Flip bit 0 when the new response would not be visible as a change.
    assign send_val = (resp == o_irq) ? (resp ^ 32'h1) : resp;

    irq_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .word_t (irq_word_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (change),
        .wdata (i_irq),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Change detection and drop accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_irq_prev <= '0;
            drop_cnt   <= '0;
        end else begin
            i_irq_prev <= i_irq;
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
`ifdef IRQ_RESPONDER_LOG_EN
            if (drop) begin
                $display("[resp_%0d] drop 0x%08x", cpu_index, i_irq);
            end
`endif
        end
    end

    // Response FSM: pop -> count down delay -> drive response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            o_irq    <= '0;
            done     <= 1'b0;
            sent_cnt <= '0;
            resp     <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        resp  <= fifo_head ^ RESP_KEY ^ cpu_index;
                        cnt   <= 9'(MIN_DELAY) + {5'd0, fifo_head[3:0]};
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= SEND;
                    end else begin
                        cnt <= cnt - 9'd1;
                    end
                end
                SEND: begin
                    o_irq    <= send_val;
                    sent_cnt <= sent_cnt + 32'd1;
                    if ((sent_cnt + 32'd1) == TRANSACTION_NB) begin
                        done <= 1'b1;
                    end
                    state <= IDLE;
`ifdef IRQ_RESPONDER_LOG_EN
                    $display("[resp_%0d] o_irq = 0x%08x (%0d/%0d)", cpu_index, send_val,
                             sent_cnt + 32'd1, TRANSACTION_NB);
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_responder.sv
// ---------------------------------------------------------------------------
// tb_irq_responder
// Two responder instances share one clock:
//   dut0 : TRANSACTION_NB=1000, MIN_DELAY=0, FIFO_DEPTH=4
//   dut1 : TRANSACTION_NB=2,    MIN_DELAY=4, FIFO_DEPTH=4, cpu_index=5
// Drivers push expected responses (value and edge number) into a scoreboard
// queue from a timing model; a monitor pops entries whenever o_irq moves.
// ---------------------------------------------------------------------------
module tb_irq_responder;

    localparam logic [31:0] KEY   = 32'hA5A5_5A5A;
    localparam int          DEPTH = 4;
    localparam int          TN0   = 1000;
    localparam int          TN1   = 2;
    localparam int          MD0   = 0;
    localparam int          MD1   = 4;
    localparam int          INF   = 32'h3FFF_FFFF;
    localparam int          NACC  = 4096;

    typedef struct {
        int          dut;
        int          cyc;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst0 = 1'b1, rst1 = 1'b1;
    logic [31:0] cpu0 = 32'd0, cpu1 = 32'd5;
    logic [31:0] irq0 = 32'd0, irq1 = 32'd0;
    logic [31:0] o0, o1;
    logic        dn0, dn1;
    logic [15:0] dc0, dc1;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int fin0 = 0, fin1 = 0;

    // Reference model state, one slot per DUT.
    exp_t        exp_q[$];
    logic [31:0] prev_in_m [2];
    logic [31:0] prev_o_m  [2];
    logic [31:0] cpu_m     [2];
    logic [15:0] drops_m   [2];
    int          n_acc     [2];
    int          n_resp    [2];
    int          last_send [2];
    int          done_e    [2];
    int          pop_t     [2][NACC];
    logic [31:0] last_o    [2];

    irq_responder #(.TRANSACTION_NB(TN0), .FIFO_DEPTH(DEPTH), .MIN_DELAY(MD0)) dut0 (
        .clk(clk), .rst(rst0), .cpu_index(cpu0), .i_irq(irq0),
        .o_irq(o0), .done(dn0), .drop_cnt(dc0));

    irq_responder #(.TRANSACTION_NB(TN1), .FIFO_DEPTH(DEPTH), .MIN_DELAY(MD1)) dut1 (
        .clk(clk), .rst(rst1), .cpu_index(cpu1), .i_irq(irq1),
        .o_irq(o1), .done(dn1), .drop_cnt(dc1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int tn(int d);
        return (d == 0) ? TN0 : TN1;
    endfunction

    function automatic int md(int d);
        return (d == 0) ? MD0 : MD1;
    endfunction

    // Advance the model for DUT d across clock edge e.
    // A request accepted at edge e is popped at max(e+1, previous send+1)
    // and answered D+2 edges after its pop.
    task automatic model_edge(int d, int e, logic [31:0] v, logic r, logic [31:0] c);
        int occ;
        int p;
        int s;
        bit pop_now;
        logic [31:0] rsp;
        logic [31:0] out;
        if (r) begin
            prev_in_m[d] = '0;
            prev_o_m[d]  = '0;
            cpu_m[d]     = c;
            drops_m[d]   = '0;
            n_acc[d]     = 0;
            n_resp[d]    = 0;
            last_send[d] = -1000;
            done_e[d]    = INF;
            for (int i = exp_q.size() - 1; i >= 0; i--)
                if (exp_q[i].dut == d) exp_q.delete(i);
            return;
        end
        if ((v == prev_in_m[d]) || (e > done_e[d])) begin
            prev_in_m[d] = v;
            return;
        end
        prev_in_m[d] = v;
        occ = 0;
        pop_now = 1'b0;
        for (int k = 0; k < n_acc[d]; k++) begin
            if (pop_t[d][k] >= e) occ++;
            if (pop_t[d][k] == e) pop_now = 1'b1;
        end
        if ((occ >= DEPTH) && !pop_now) begin
            if (drops_m[d] != 16'hFFFF) drops_m[d] = drops_m[d] + 16'd1;
            return;
        end
        if (n_resp[d] < tn(d)) begin
            p = (e + 1 > last_send[d] + 1) ? e + 1 : last_send[d] + 1;
            s = p + md(d) + int'(v[3:0]) + 2;
            last_send[d] = s;
            rsp = v ^ KEY ^ cpu_m[d];
            out = (rsp == prev_o_m[d]) ? (rsp ^ 32'h1) : rsp;
            prev_o_m[d] = out;
            exp_q.push_back('{dut: d, cyc: s, val: out});
            n_resp[d]++;
            if (n_resp[d] == tn(d)) done_e[d] = s;
        end else begin
            p = INF;
        end
        if (n_acc[d] < NACC) begin
            pop_t[d][n_acc[d]] = p;
            n_acc[d]++;
        end
    endtask

    task automatic step(int d, logic [31:0] v, logic r, logic [31:0] c);
        @(negedge clk);
        if (d == 0) begin
            rst0 = r; irq0 = v;
            if (r) cpu0 = c;
        end else begin
            rst1 = r; irq1 = v;
            if (r) cpu1 = c;
        end
        model_edge(d, cyc + 1, v, r, c);
    endtask

    task automatic hold(int d, logic [31:0] v, int n);
        repeat (n) step(d, v, 1'b0, '0);
    endtask

    task automatic chk(string name, int d, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s dut%0d edge %0d: got 0x%08x, expected 0x%08x", name, d, cyc, act, req);
        end
    endtask

    task automatic monitor_dut(int d);
        logic [31:0] o;
        logic        dn;
        logic [15:0] dc;
        logic        r;
        int          idx;
        o  = (d == 0) ? o0 : o1;
        dn = (d == 0) ? dn0 : dn1;
        dc = (d == 0) ? dc0 : dc1;
        r  = (d == 0) ? rst0 : rst1;
        if (r) begin
            chk("reset_o_irq", d, o, 32'h0);
            last_o[d] = '0;
        end else if (o !== last_o[d]) begin
            idx = -1;
            foreach (exp_q[i]) if ((idx < 0) && (exp_q[i].dut == d)) idx = i;
            if (idx < 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_update dut%0d edge %0d: got 0x%08x, expected no change from 0x%08x",
                         d, cyc, o, last_o[d]);
            end else begin
                chk("resp_value", d, o, exp_q[idx].val);
                chk("resp_edge", d, cyc, exp_q[idx].cyc);
                exp_q.delete(idx);
            end
            last_o[d] = o;
        end
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if ((exp_q[i].dut == d) && (exp_q[i].cyc < cyc)) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missed_update dut%0d edge %0d: got no update, expected 0x%08x at edge %0d",
                         d, cyc, exp_q[i].val, exp_q[i].cyc);
                exp_q.delete(i);
            end
        end
        chk("drop_cnt", d, {16'h0, dc}, {16'h0, drops_m[d]});
        chk("done", d, {31'h0, dn}, {31'h0, logic'(cyc >= done_e[d])});
    endtask

    always @(posedge clk) begin
        #1;
        monitor_dut(0);
        monitor_dut(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            model_edge(d, 0, '0, 1'b1, (d == 0) ? 32'd0 : 32'd5);
            last_o[d] = '0;
        end
    end

    // dut0: directed scenarios, then random traffic with occasional resets.
    initial begin : drive0
        logic [31:0] cur;
        step(0, 32'h0, 1'b1, 32'd0);
        hold(0, 32'h0, 3);
        step(0, 32'h0000_0003, 1'b0, '0);           // -> A5A5_5A59 six edges later
        hold(0, 32'h0000_0003, 20);
        step(0, 32'h0, 1'b1, 32'd0);
        hold(0, 32'h0, 2);
        step(0, 32'hA5A5_5A5A, 1'b0, '0);           // response collides with 0 -> 1
        hold(0, 32'hA5A5_5A5A, 25);
        step(0, 32'h0, 1'b1, 32'd0);
        hold(0, 32'h0, 2);
        for (int k = 1; k <= 6; k++) step(0, 32'(k * 16 + 15), 1'b0, '0);
        hold(0, 32'h6F, 110);
        for (int k = 10; k <= 12; k++) step(0, 32'(k * 16 + 15), 1'b0, '0);
        hold(0, 32'hCF, 4);                          // head in WAIT, two queued
        step(0, 32'hCF, 1'b1, 32'd0);
        hold(0, 32'hCF, 25);
        step(0, 32'h0000_0017, 1'b0, '0);
        hold(0, 32'h0000_0017, 30);
        cur = 32'h17;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                step(0, cur, 1'b1, 32'($urandom_range(0, 15)));
            end else begin
                if ($urandom_range(0, 4) == 0) begin
                    if ($urandom_range(0, 9) == 0) cur = prev_o_m[0] ^ KEY ^ cpu_m[0];
                    else cur = $urandom;
                end
                step(0, cur, 1'b0, '0);
            end
        end
        hold(0, cur, 200);
        fin0 = 1;
    end

    // dut1: short run to done, then traffic that must be ignored.
    initial begin : drive1
        logic [31:0] cur;
        step(1, 32'h0, 1'b1, 32'd5);
        hold(1, 32'h0, 3);
        step(1, 32'h1234_5670, 1'b0, '0);           // -> B791_0C2F seven edges later
        hold(1, 32'h1234_5670, 20);
        step(1, 32'h0000_0041, 1'b0, '0);
        hold(1, 32'h0000_0041, 20);
        step(1, 32'h0000_0099, 1'b0, '0);           // after done: ignored
        hold(1, 32'h0000_0099, 20);
        cur = 32'h99;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 2) == 0) cur = $urandom;
            step(1, cur, 1'b0, '0);
        end
        step(1, 32'h0, 1'b1, 32'($urandom_range(0, 7)));
        hold(1, 32'h0, 2);
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) cur = $urandom;
            step(1, cur, 1'b0, '0);
        end
        hold(1, cur, 60);
        fin1 = 1;
    end

    initial begin : finish_blk
        int t;
        wait ((fin0 != 0) && (fin1 != 0));
        t = 0;
        while ((exp_q.size() != 0) && (t < 600)) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending responses, expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
